// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one unified memory between the CPU and the loader/debug port.
// Revision 1.0
`default_nettype none

module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_ack,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    input  logic                  i_ldr_req,
    input  logic                  i_ldr_we,
    input  logic [ADDR_WIDTH-1:0] i_ldr_addr,
    input  logic [DATA_WIDTH-1:0] i_ldr_wdata,
    input  logic                  i_ldr_lock,
    output logic                  o_ldr_ack,
    output logic [DATA_WIDTH-1:0] o_ldr_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [2:0] C_LAT    = 3'(MEM_LATENCY);

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_lock_flag;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;
    logic                  w_any_req;
    logic                  w_grant_ldr;

    // Loader wins when alone, when it holds the lock, or when the CPU was served last.
    assign w_any_req   = i_cpu_req | i_ldr_req;
    assign w_grant_ldr = i_ldr_req & (~i_cpu_req | r_lock_flag | ~r_last_owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_lock_flag  <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_ldr;
                        r_we    <= w_grant_ldr ? i_ldr_we    : i_cpu_we;
                        r_addr  <= w_grant_ldr ? i_ldr_addr  : i_cpu_addr;
                        r_wdata <= w_grant_ldr ? i_ldr_wdata : i_cpu_wdata;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= C_LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        if (r_owner) begin
                            r_ldr_rdata <= i_mem_rdata;
                        end else begin
                            r_cpu_rdata <= i_mem_rdata;
                        end
                        r_state <= S_DONE;
                    end
                    r_cnt <= r_cnt - 3'd1;
                end
                default: begin
                    r_last_owner <= r_owner;
                    r_lock_flag  <= r_owner & i_ldr_lock;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_we    = (r_state == S_ACCESS) & r_we;
    assign o_cpu_ack   = (r_state == S_DONE) & ~r_owner;
    assign o_ldr_ack   = (r_state == S_DONE) & r_owner;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ldr_rdata = r_ldr_rdata;
    assign o_busy      = (r_state != S_IDLE);
    assign o_owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (latency 1 and latency 3 instances).
// Revision 1.0
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [9:0]  cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_ack, ldr_ack, mem_we, busy, owner;
    logic [31:0] cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic        b_cpu_req;
    logic [9:0]  b_cpu_addr;
    logic        b_zero_1;
    logic [9:0]  b_zero_a;
    logic [31:0] b_zero_d;
    logic        b_cpu_ack, b_ldr_ack, b_mem_we, b_busy, b_owner;
    logic [31:0] b_cpu_rdata, b_ldr_rdata, b_mem_wdata, b_mem_rdata;
    logic [9:0]  b_mem_addr;

    logic [31:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
        .i_ldr_lock(ldr_lock), .o_ldr_ack(ldr_ack), .o_ldr_rdata(ldr_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_owner(owner)
    );

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(b_cpu_req), .i_cpu_we(b_zero_1), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_zero_d),
        .o_cpu_ack(b_cpu_ack), .o_cpu_rdata(b_cpu_rdata),
        .i_ldr_req(b_zero_1), .i_ldr_we(b_zero_1), .i_ldr_addr(b_zero_a), .i_ldr_wdata(b_zero_d),
        .i_ldr_lock(b_zero_1), .o_ldr_ack(b_ldr_ack), .o_ldr_rdata(b_ldr_rdata),
        .o_mem_addr(b_mem_addr), .o_mem_we(b_mem_we), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
        .o_busy(b_busy), .o_owner(b_owner)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq [0:7];
    int n, cyc, ack_cnt;
    logic overlap, drop_next, got;

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
        b_cpu_req = 0; b_cpu_addr = '0; b_zero_1 = 0; b_zero_a = '0; b_zero_d = '0;
        b_mem_rdata = '0;
        mem[4] = 32'h2002_0005;
        mem[8] = 32'h0000_8888;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_acks", {cpu_ack, ldr_ack, mem_we}, 0);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        rst_n = 1'b1;
        tick();

        // CPU read, latency 1
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        tick();
        check("rd_mem_addr", mem_addr, 10'h004);
        check("rd_busy_t1", busy, 1);
        check("rd_we_t1", mem_we, 0);
        tick();
        check("rd_ack_t2", cpu_ack, 0);
        check("rd_busy_t2", busy, 1);
        tick();
        check("rd_ack_t3", cpu_ack, 1);
        check("rd_ldr_ack_t3", ldr_ack, 0);
        check("rd_rdata", cpu_rdata, 32'h2002_0005);
        check("rd_busy_t3", busy, 1);
        cpu_req = 0;
        tick();
        check("rd_busy_t4", busy, 0);
        check("rd_ack_t4", cpu_ack, 0);

        // Loader write
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h010; ldr_wdata = 32'hDEAD_BEEF;
        tick();
        check("wr_we_t1", mem_we, 1);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_addr", mem_addr, 10'h010);
        check("wr_owner", owner, 1);
        tick();
        check("wr_we_t2", mem_we, 0);
        check("wr_ack", {ldr_ack, cpu_ack}, 2'b10);
        ldr_req = 0;
        check("wr_mem", mem[16], 32'hDEAD_BEEF);
        tick();
        check("wr_cpu_rdata_held", cpu_rdata, 32'h2002_0005);

        // Round robin from reset, both reading continuously
        rst_n = 0;
        tick();
        rst_n = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h008;
        n = 0; cyc = 0; overlap = 0;
        for (int i = 0; i < 8; i++) seq[i] = 9;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (cpu_ack && ldr_ack) overlap = 1;
            if (cpu_ack) begin seq[n] = 0; n++; end
            else if (ldr_ack) begin seq[n] = 1; n++; end
        end
        cpu_req = 0; ldr_req = 0;
        check("rr_count", n, 4);
        check("rr_overlap", overlap, 0);
        check("rr_order", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}, 16'h0101);
        check("rr_ldr_rdata", ldr_rdata, 32'h0000_8888);
        tick();

        // Locked loader burst while the CPU keeps requesting
        ldr_req = 1; ldr_we = 1; ldr_addr = 10'h000; ldr_wdata = 32'hA0; ldr_lock = 1;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        n = 0; cyc = 0; overlap = 0; drop_next = 0;
        for (int i = 0; i < 8; i++) seq[i] = 9;
        while (n < 5 && cyc < 60) begin
            tick();
            cyc++;
            if (drop_next) begin ldr_lock = 0; drop_next = 0; end
            if (cpu_ack && ldr_ack) overlap = 1;
            if (cpu_ack) begin seq[n] = 0; n++; end
            else if (ldr_ack) begin
                seq[n] = 1; n++;
                ldr_addr = 10'(n);
                ldr_wdata = 32'hA0 + 32'(n);
                if (n == 3) drop_next = 1;
            end
        end
        cpu_req = 0; ldr_req = 0;
        check("lk_count", n, 5);
        check("lk_overlap", overlap, 0);
        check("lk_order", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0]}, 20'h11110);
        check("lk_mem", {mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0]}, 32'hA0A1A2A3);
        tick();

        // Latency 3 read at top address
        b_cpu_req = 1; b_cpu_addr = 10'h3FF;
        tick();
        check("l3_addr", b_mem_addr, 10'h3FF);
        b_mem_rdata = 32'h1111_1111;
        tick();
        b_mem_rdata = 32'h2222_2222;
        tick();
        b_mem_rdata = 32'h3333_3333;
        check("l3_ack_t3", b_cpu_ack, 0);
        tick();
        b_mem_rdata = 32'h4444_4444;
        check("l3_ack_t4", b_cpu_ack, 0);
        check("l3_busy_t4", b_busy, 1);
        tick();
        b_mem_rdata = 32'h5555_5555;
        check("l3_ack_t5", b_cpu_ack, 1);
        check("l3_rdata", b_cpu_rdata, 32'h4444_4444);
        b_cpu_req = 0;
        tick();
        check("l3_idle", b_busy, 0);

        // Reset during WAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        tick();
        tick();
        check("rw_busy_wait", busy, 1);
        rst_n = 0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_mem_we", mem_we, 0);
        check("rw_cpu_rdata", cpu_rdata, 0);
        cpu_req = 0;
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_cnt += int'(cpu_ack) + int'(ldr_ack);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_cnt += int'(cpu_ack) + int'(ldr_ack);
        end
        check("rw_no_ack", ack_cnt, 0);

        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        ldr_req = 1; ldr_we = 0; ldr_addr = 10'h008;
        got = 0; cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (cpu_ack || ldr_ack) begin
                got = 1;
                check("rw_first_grant", {cpu_ack, ldr_ack}, 2'b10);
            end
        end
        check("rw_ack_seen", got, 1);
        cpu_req = 0; ldr_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single unified instruction/data memory of the multicycle MIPS core between the CPU control/datapath (port `cpu`) and the program loader/debug port (port `ldr`). Each transaction is one word-wide read or write. Ports are served round-robin on ties, and the loader can lock the memory for burst program loading. The block sits between both requesters and the memory macro, and owns every memory address, write-enable and write-data line.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 10, word address width
- MEM_LATENCY, 1, cycles from address-registered edge to valid `mem_rdata`; legal range 1..7
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU requests a transaction; held high until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ack  out  1  one-cycle pulse: CPU transaction complete
- cpu_rdata  out  DATA_WIDTH  last CPU read data; held until the next CPU read completes
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same meaning as the `cpu_*` inputs, for the loader
- ldr_lock  in  1  loader requests to keep ownership after its current transaction
- ldr_ack  out  1  one-cycle pulse: loader transaction complete
- ldr_rdata  out  DATA_WIDTH  last loader read data; held
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever the state is not IDLE
- owner  out  1  current or last owner: 0 = cpu, 1 = ldr

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE, arbitration:
  - Only one requester high: that requester wins.
  - Both high and `lock_flag` = 1: loader wins.
  - Both high otherwise: the winner is the opposite of `last_owner`.
  - The winner's addr, we and wdata are latched into internal registers, along with `owner`.
  - Next state is ACCESS.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched registers. `mem_addr` is held through WAIT and DONE.
  - `mem_we` equals the latched `we`, in this state only.
  - Write: next state is DONE.
  - Read: the down-counter is loaded with MEM_LATENCY and the next state is WAIT.
- WAIT: the counter decrements each cycle. In the cycle where the counter is 1, `mem_rdata` is captured into the owner's rdata register and the next state is DONE.
- DONE:
  - The owner's ack is high for this cycle only.
  - `last_owner` is set to `owner`.
  - `lock_flag` is set to `owner & ldr_lock`.
  - Next state is IDLE.
- `lock_flag` only matters when `ldr_req` is high in IDLE. A CPU-only request is served even while the flag is set.
- If a requester drops req mid-transaction, the transaction still completes and the ack still pulses.
- Inputs are sampled only in IDLE. Changes to addr, we or wdata after that are ignored.
- MEM_LATENCY = 0 is illegal and out of scope.

## Timing
- Reset values: state IDLE; all of `mem_addr`, `mem_we`, `mem_wdata`, `cpu_ack`, `ldr_ack`, `cpu_rdata`, `ldr_rdata`, `busy` and `owner` are 0; `last_owner` = 1, so the CPU wins the first tie; `lock_flag` = 0.
- Let T be the IDLE cycle in which a request is sampled. Write: ACCESS at T+1, ack at T+2.
- Read: ACCESS at T+1, WAIT T+2..T+1+L, rdata captured at the end of T+1+L, ack at T+2+L, where L = MEM_LATENCY.
- After DONE there is always one IDLE cycle before the next ACCESS. Back-to-back writes therefore take 3 cycles each.
- `mem_we` is never high outside ACCESS. Exactly one `mem_we` pulse occurs per write.
- The acks are mutually exclusive and are never asserted outside DONE.
- Reset asserted in any state returns the block to IDLE immediately, with reset values. The aborted transaction produces no ack, and the rdata registers are cleared.

## Test plan
- CPU read, L=1: `cpu_addr` = 0x004, memory returns 0x20020005 → `mem_addr` = 0x004 from T+1, `cpu_ack` pulses at T+3, `cpu_rdata` = 0x20020005, `ldr_ack` stays 0, `busy` is high for T+1..T+3.
- Loader write: `ldr_addr` = 0x010, `ldr_wdata` = 0xDEADBEEF → `mem_we` high only at T+1 with `mem_wdata` = 0xDEADBEEF, `ldr_ack` at T+2, `owner` = 1.
- Both ports request reads continuously from reset, `ldr_lock` = 0 → grant order cpu, ldr, cpu, ldr; acks alternate with no overlap.
- Loader issues 4 writes (addresses 0x000..0x003) with `ldr_lock` = 1 while `cpu_req` is held → 4 consecutive loader acks, then a CPU ack. Drop `ldr_lock` on the 4th write → the CPU is granted next.
- MEM_LATENCY = 3 read at address 0x3FF → `cpu_ack` at T+5, `cpu_rdata` equals the memory word present at T+4.
- Reset pulsed during WAIT of a CPU read → `busy`, `mem_we` and `cpu_rdata` are 0 immediately and no ack is produced. After release, a simultaneous request from both ports grants the CPU first.
